// File: rtl/stick_pkg.sv
// Shared types and helpers for the analog stick conditioning path.
package stick_pkg;

    typedef enum logic [1:0] {
        CALIB = 2'd0,
        RUN   = 2'd1,
        STALE = 2'd2
    } state_t;

    localparam logic [7:0] STICK_CENTER = 8'd128;

    // Clamp a signed 10-bit result into the unsigned 8-bit stick range.
    function automatic logic [7:0] sat8(input logic signed [9:0] v);
        logic [7:0] r;
        if (v < 10'sd0) begin
            r = '0;
        end else if (v > 10'sd255) begin
            r = '1;
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/stick_axis.sv
// One stick axis: calibration accumulator, centre register, deadzone/saturate path, output register.
module stick_axis #(
    parameter int unsigned CALIB_FRAMES = 4,
    parameter int unsigned DEADZONE     = 8,
    parameter int unsigned STICK_CENTER = 128
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] raw,
    input  logic       acc_clr,
    input  logic       acc_en,
    input  logic       centre_load,
    input  logic       out_en,
    input  logic       force_center,
    output logic [7:0] stick
);
    import stick_pkg::*;

    localparam int unsigned LOG2  = $clog2(CALIB_FRAMES);
    localparam int unsigned ACC_W = 8 + LOG2;
    localparam logic signed [9:0] DZ  = 10'(DEADZONE);
    localparam logic signed [9:0] CTR = 10'(STICK_CENTER);

    logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
    logic [7:0]       centre_q, centre_d;
    logic [7:0]       stick_q, stick_d;
    logic signed [9:0] diff, adj, shifted;

    always_comb begin
        acc_sum  = acc_q + ACC_W'(raw);
        acc_d    = acc_q;
        centre_d = centre_q;
        if (acc_clr) begin
            acc_d = '0;
        end else if (acc_en) begin
            // Final sample goes straight into the centre; the accumulator is left empty.
            if (centre_load) begin
                centre_d = acc_sum[LOG2 +: 8];
                acc_d    = '0;
            end else begin
                acc_d = acc_sum;
            end
        end
    end

    always_comb begin
        diff = $signed({2'b00, raw}) - $signed({2'b00, centre_q});
        if (diff > DZ) begin
            adj = diff - DZ;
        end else if (diff < -DZ) begin
            adj = diff + DZ;
        end else begin
            adj = '0;
        end
        shifted = CTR + adj;

        stick_d = stick_q;
        if (force_center) begin
            stick_d = 8'(STICK_CENTER);
        end else if (out_en) begin
            stick_d = sat8(shifted);
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            acc_q    <= '0;
            centre_q <= 8'(STICK_CENTER);
            stick_q  <= 8'(STICK_CENTER);
        end else begin
            acc_q    <= acc_d;
            centre_q <= centre_d;
            stick_q  <= stick_d;
        end
    end

    assign stick = stick_q;

endmodule

// File: rtl/stick_conditioner.sv
// Calibrates, deadzones and saturates raw stick samples; forces neutral when reports go stale.
module stick_conditioner #(
    parameter int unsigned CALIB_FRAMES = 4,
    parameter int unsigned DEADZONE     = 8,
    parameter int unsigned STALE_FRAMES = 8,
    parameter int unsigned STICK_CENTER = 128
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] raw_x,
    input  logic [7:0] raw_y,
    input  logic       raw_valid,
    input  logic       recal,
    output logic [7:0] xstick,
    output logic [7:0] ystick,
    output logic       stick_valid,
    output logic       calibrated,
    output logic       stale
);
    import stick_pkg::*;

    localparam int unsigned CNT_W  = $clog2(CALIB_FRAMES) + 1;
    localparam int unsigned MISS_W = $clog2(STALE_FRAMES + 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic              stick_valid_q, stick_valid_d;
    logic              calibrated_q, calibrated_d;
    logic              stale_q, stale_d;

    logic acc_clr, acc_en, centre_load, out_en, force_center;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        miss_d        = miss_q;
        stick_valid_d = 1'b0;
        calibrated_d  = calibrated_q;
        stale_d       = stale_q;
        acc_clr       = 1'b0;
        acc_en        = 1'b0;
        centre_load   = 1'b0;
        out_en        = 1'b0;
        force_center  = 1'b0;

        if (recal) begin
            state_d      = CALIB;
            cnt_d        = '0;
            miss_d       = '0;
            calibrated_d = 1'b0;
            stale_d      = 1'b0;
            acc_clr      = 1'b1;
            force_center = 1'b1;
        end else begin
            unique case (state_q)
                CALIB: begin
                    if (raw_valid) begin
                        acc_en = 1'b1;
                        cnt_d  = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(CALIB_FRAMES - 1)) begin
                            centre_load  = 1'b1;
                            cnt_d        = '0;
                            miss_d       = '0;
                            calibrated_d = 1'b1;
                            state_d      = RUN;
                        end
                    end
                end
                RUN: begin
                    if (raw_valid) begin
                        out_en        = 1'b1;
                        stick_valid_d = 1'b1;
                        miss_d        = '0;
                    end else begin
                        if (miss_q != MISS_W'(STALE_FRAMES)) begin
                            miss_d = miss_q + MISS_W'(1);
                        end
                        if (miss_q >= MISS_W'(STALE_FRAMES - 1)) begin
                            state_d      = STALE;
                            stale_d      = 1'b1;
                            force_center = 1'b1;
                        end
                    end
                end
                STALE: begin
                    if (raw_valid) begin
                        out_en        = 1'b1;
                        stick_valid_d = 1'b1;
                        stale_d       = 1'b0;
                        miss_d        = '0;
                        state_d       = RUN;
                    end
                end
                default: begin
                    state_d = CALIB;
                end
            endcase
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= CALIB;
            cnt_q         <= '0;
            miss_q        <= '0;
            stick_valid_q <= 1'b0;
            calibrated_q  <= 1'b0;
            stale_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            miss_q        <= miss_d;
            stick_valid_q <= stick_valid_d;
            calibrated_q  <= calibrated_d;
            stale_q       <= stale_d;
        end
    end

    stick_axis #(
        .CALIB_FRAMES(CALIB_FRAMES),
        .DEADZONE    (DEADZONE),
        .STICK_CENTER(STICK_CENTER)
    ) u_axis_x (
        .frame_clk   (frame_clk),
        .Reset       (Reset),
        .raw         (raw_x),
        .acc_clr     (acc_clr),
        .acc_en      (acc_en),
        .centre_load (centre_load),
        .out_en      (out_en),
        .force_center(force_center),
        .stick       (xstick)
    );

    stick_axis #(
        .CALIB_FRAMES(CALIB_FRAMES),
        .DEADZONE    (DEADZONE),
        .STICK_CENTER(STICK_CENTER)
    ) u_axis_y (
        .frame_clk   (frame_clk),
        .Reset       (Reset),
        .raw         (raw_y),
        .acc_clr     (acc_clr),
        .acc_en      (acc_en),
        .centre_load (centre_load),
        .out_en      (out_en),
        .force_center(force_center),
        .stick       (ystick)
    );

    assign stick_valid = stick_valid_q;
    assign calibrated  = calibrated_q;
    assign stale       = stale_q;

endmodule

// File: doc/stick_conditioner.md
Name: stick_conditioner

Overview:
Per-frame conditioning stage directly upstream of the ball motion block. It takes raw GameCube analog stick samples (already decoded and synchronised to frame_clk) and calibrates the stick centre after reset or on request. It then applies a symmetric deadzone, saturates the result, and forces the sticks to neutral when controller reports stop arriving. Its xstick/ystick outputs drive the ball block's stick inputs.

Parameters:
CALIB_FRAMES, 4, number of valid samples averaged for calibration; must be a power of 2 (2..16)
DEADZONE, 8, half-width of the deadzone around the calibrated centre, in raw counts
STALE_FRAMES, 8, consecutive frame_clk cycles without raw_valid before outputs are forced to neutral
STICK_CENTER, 128, neutral output code

Ports:
frame_clk  in  1  frame clock; all state updates on its rising edge
Reset  in  1  asynchronous, active-high reset
raw_x  in  8  raw stick X sample, unsigned
raw_y  in  8  raw stick Y sample, unsigned
raw_valid  in  1  raw_x/raw_y are valid this cycle; single-cycle qualifier, no backpressure
recal  in  1  request recalibration; level sampled each cycle
xstick  out  8  conditioned X, unsigned, STICK_CENTER = neutral
ystick  out  8  conditioned Y, unsigned, STICK_CENTER = neutral
stick_valid  out  1  one-cycle pulse when xstick/ystick were updated from a new sample
calibrated  out  1  high once a centre has been captured
stale  out  1  high while in STALE state

Behaviour:
- Reset (async, active-high) applies the following values:
  - state = CALIB; accumulators, sample count and miss count = 0
  - centre_x = centre_y = STICK_CENTER
  - xstick = ystick = STICK_CENTER
  - stick_valid = 0, calibrated = 0, stale = 0
- All outputs are registered.
- State CALIB:
  - Outputs are held at STICK_CENTER; stick_valid stays 0.
  - On each raw_valid: acc_x += raw_x, acc_y += raw_y (width 8+log2(CALIB_FRAMES)); cnt++.
  - On the raw_valid that makes cnt == CALIB_FRAMES: centre = acc >> log2(CALIB_FRAMES) (truncating); next state RUN; calibrated = 1 from the next cycle.
  - That sample is consumed by calibration only and produces no output.
- State RUN, on raw_valid (per axis, signed 10-bit arithmetic):
  - d = raw - centre
  - If |d| <= DEADZONE, d' = 0; else d' = d - sign(d)*DEADZONE.
  - out = STICK_CENTER + d', saturated to [0,255].
  - Latency is 1 cycle: output and stick_valid=1 appear the cycle after raw_valid. stick_valid is 0 in all other cycles.
  - Without raw_valid, outputs hold their value.
- Miss counter (RUN only):
  - Cleared on raw_valid; otherwise incremented and saturating.
  - When it reaches STALE_FRAMES, next state is STALE.
- State STALE:
  - Outputs are forced to STICK_CENTER on entry (registered, next cycle); stale = 1; stick_valid = 0.
  - On raw_valid: the sample is processed exactly as in RUN (output plus stick_valid the next cycle), stale = 0, miss counter cleared, next state RUN.
- recal = 1 in any state:
  - Next state is CALIB; acc and cnt are cleared; calibrated = 0; outputs = STICK_CENTER; stale = 0; any raw_valid in the same cycle is discarded.
  - While recal is held, the block stays in CALIB with counters cleared.
- Reset asserted mid-calibration or mid-run returns the block to the reset state immediately; no partial centre is retained.
- centre is never modified outside CALIB completion.

Decomposition:
- Package stick_pkg holds:
  - state enum (CALIB, RUN, STALE)
  - STICK_CENTER constant
  - function sat8 (signed 10-bit to unsigned 8-bit clamp)
- Sub-module stick_axis holds the per-axis accumulator, centre register, deadzone/saturate path and output register. It is instantiated twice (X, Y).
- The FSM, miss counter, calibration count and flag outputs live in stick_conditioner.

Test Plan:
- Reset, then 4 raw_valid samples with x = 120,124,128,132 and y = 128 ×4 -> centre_x = 126, centre_y = 128; calibrated rises; no stick_valid during CALIB; xstick = ystick = 128 throughout.
- Centre 128/128, raw_x = 200, raw_y = 133 -> next cycle xstick = 192, ystick = 128, stick_valid = 1 for exactly one cycle.
- Saturation: with centre_x = 140, raw_x = 0 -> xstick = 0. With centre_y = 100, raw_y = 255 -> ystick = 255.
- Deadzone boundary at centre 128: raw 136 -> 128, raw 137 -> 129, raw 120 -> 128, raw 119 -> 127.
- Staleness: in RUN with xstick = 192, no raw_valid for 8 cycles -> stale = 1 and xstick = ystick = 128. Next raw_x = 200 -> xstick = 192, stale = 0.
- recal asserted in the same cycle as raw_valid while in RUN -> sample discarded, calibrated = 0, outputs 128, and 4 new samples are required before output resumes. Async Reset asserted mid-CALIB (after 2 samples) -> after release, 4 full samples are still required.
